// File: rtl/vm_pkg.sv
// Shared types for the multi-item vending controller: FSM states,
// coin_type encodings and the coin value lookup.
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vm_state_e;

    localparam logic [1:0] COIN_5   = 2'b00;
    localparam logic [1:0] COIN_10  = 2'b01;
    localparam logic [1:0] COIN_25  = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam int COIN_VAL_W = 5;

    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] ct);
        case (ct)
            COIN_5:  return 5'd5;
            COIN_10: return 5'd10;
            COIN_25: return 5'd25;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters, loaded with STOCK_INIT on reset and decremented on each vend.
module vm_stock_bank
    import vm_pkg::*;
#(
    parameter int                 NUM_ITEMS  = 4,
    parameter int                 STOCK_W    = 4,
    parameter logic [STOCK_W-1:0] STOCK_INIT = 4'd3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dec_en,
    input  logic [$clog2(NUM_ITEMS)-1:0] dec_idx,
    input  logic [$clog2(NUM_ITEMS)-1:0] rd_idx,
    output logic                         rd_empty
);

    logic [STOCK_W-1:0] r_stock [NUM_ITEMS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_stock[i] <= STOCK_INIT;
            end
        end else if (dec_en) begin
            r_stock[dec_idx] <= r_stock[dec_idx] - STOCK_W'(1);
        end
    end

    // Indices past the last item read as empty so they report sold_out.
    assign rd_empty = (int'(rd_idx) >= NUM_ITEMS) || (r_stock[rd_idx] == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller. States: IDLE no credit | CREDIT holding credit |
// VEND one dispense cycle | CHANGE paying credit back as 5-unit coins.
module vending_machine_multi
    import vm_pkg::*;
#(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            CREDIT_W   = 8,
    parameter int                            CREDIT_MAX = 100,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                            STOCK_W    = 4,
    parameter logic [STOCK_W-1:0]            STOCK_INIT = 4'd3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_type,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel,
    input  logic                         cancel,
    input  logic                         change_ready,
    output logic                         dispense,
    output logic [$clog2(NUM_ITEMS)-1:0] dispense_item,
    output logic                         change_pulse,
    output logic                         coin_reject,
    output logic                         insufficient,
    output logic                         sold_out,
    output logic                         busy,
    output logic [CREDIT_W-1:0]          credit
);

    vm_state_e                    r_state;
    logic [CREDIT_W-1:0]          r_credit;
    logic                         r_dispense;
    logic [$clog2(NUM_ITEMS)-1:0] r_disp_item;
    logic                         r_coin_reject;
    logic                         r_insufficient;
    logic                         r_sold_out;
    logic                         r_busy;

    logic [COIN_VAL_W-1:0] w_coin_val;
    logic [CREDIT_W:0]     w_sum;
    logic                  w_coin_ok;
    logic [CREDIT_W-1:0]   w_price;
    logic                  w_accepting;
    logic                  w_cancel_go;
    logic                  w_sel_go;
    logic                  w_sel_empty;
    logic                  w_vend_ok;

    // One extra bit on the sum so an over-limit coin can never wrap into range.
    assign w_coin_val  = coin_value(coin_type);
    assign w_sum       = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_val);
    assign w_coin_ok   = (coin_type != COIN_BAD) && (w_sum <= (CREDIT_W+1)'(CREDIT_MAX));
    assign w_price     = PRICES[sel*CREDIT_W +: CREDIT_W];
    assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
    assign w_cancel_go = cancel && (r_state == ST_CREDIT);
    assign w_sel_go    = sel_valid && w_accepting && !w_cancel_go;
    assign w_vend_ok   = w_sel_go && !w_sel_empty && (w_price <= r_credit);

    vm_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_W    (STOCK_W),
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .clk      (clk),
        .rst_n    (rst_n),
        .dec_en   (w_vend_ok),
        .dec_idx  (sel),
        .rd_idx   (sel),
        .rd_empty (w_sel_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_dispense     <= 1'b0;
            r_disp_item    <= '0;
            r_coin_reject  <= 1'b0;
            r_insufficient <= 1'b0;
            r_sold_out     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_dispense     <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_insufficient <= 1'b0;
            r_sold_out     <= 1'b0;
            case (r_state)
                ST_IDLE, ST_CREDIT: begin
                    if (w_cancel_go) begin
                        r_coin_reject <= coin_valid;
                        r_state       <= ST_CHANGE;
                        r_busy        <= 1'b1;
                    end else if (w_sel_go) begin
                        r_coin_reject <= coin_valid;
                        if (w_sel_empty) begin
                            r_sold_out <= 1'b1;
                        end else if (!w_vend_ok) begin
                            r_insufficient <= 1'b1;
                        end else begin
                            r_credit    <= r_credit - w_price;
                            r_dispense  <= 1'b1;
                            r_disp_item <= sel;
                            r_state     <= ST_VEND;
                            r_busy      <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (w_coin_ok) begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                            r_state  <= ST_CREDIT;
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end
                ST_VEND: begin
                    r_coin_reject <= coin_valid;
                    if (r_credit != '0) begin
                        r_state <= ST_CHANGE;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_CHANGE: begin
                    r_coin_reject <= coin_valid;
                    if (change_ready) begin
                        r_credit <= r_credit - CREDIT_W'(5);
                        if (r_credit == CREDIT_W'(5)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dispense      = r_dispense;
    assign dispense_item = r_disp_item;
    assign coin_reject   = r_coin_reject;
    assign insufficient  = r_insufficient;
    assign sold_out      = r_sold_out;
    assign busy          = r_busy;
    assign credit        = r_credit;
    // The pay-out intent is registered; the hopper handshake gates it the same cycle.
    assign change_pulse  = (r_state == ST_CHANGE) && change_ready;

endmodule
